branch_resolve_ctrl: RTL

ID-stage branch sequencer for the pipelined CPU. Detects when a branch's source registers are not yet forwardable and stalls the front end for the required number of cycles. It then presents the branch type to the branch comparator and, on a taken result, redirects the PC and flushes IF/ID. It also keeps saturating branch, taken and stall statistics.

---
 rtl/branch_resolve_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: stalls on unforwardable operands,
// evaluates the branch, redirects the PC and keeps statistics.
module branch_resolve_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_id_branch,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic [31:0]      i_id_target,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_mem_memread,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_taken,
  output logic [2:0]       o_cmp_branch,
  output logic             o_stall,
  output logic             o_flush_ifid,
  output logic             o_pc_sel,
  output logic [31:0]      o_pc_target,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_taken_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    EVAL
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  remaining, remaining_nx;
  logic [2:0]  lat_type;
  logic [31:0] lat_tgt;

  logic        valid, use_rt;
  logic        ex_hit, mem_hit;
  logic [1:0]  need;
  logic        eval, stall, latch_en;
  logic [2:0]  eval_type;
  logic [31:0] eval_tgt;
  logic        redirect;

  function automatic logic uses(
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       rt_used
  );
    return (rd != 5'd0) &&
           ((rd == rs) || (rt_used && rd == rt));
  endfunction

  assign valid = (i_id_branch >= 3'b001) &&
                 (i_id_branch <= 3'b101);
  assign use_rt = (i_id_branch == 3'b001) ||
                  (i_id_branch == 3'b010);

  assign ex_hit = i_ex_regwrite &&
    uses(i_ex_rd, i_id_rs, i_id_rt, use_rt);
  assign mem_hit = i_mem_memread &&
    uses(i_mem_rd, i_id_rs, i_id_rt, use_rt);

  // Max of all matches: an EX load dominates everything else.
  always_comb begin
    need = 2'd0;
    if (ex_hit && i_ex_memread)
      need = 2'd2;
    else if (ex_hit || mem_hit)
      need = 2'd1;
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    eval         = 1'b0;
    stall        = 1'b0;
    latch_en     = 1'b0;
    eval_type    = lat_type;
    eval_tgt     = lat_tgt;
    unique case (state)
      IDLE: begin
        if (valid) begin
          if (need == 2'd0) begin
            eval      = 1'b1;
            eval_type = i_id_branch;
            eval_tgt  = i_id_target;
          end else begin
            stall        = 1'b1;
            latch_en     = 1'b1;
            remaining_nx = need - 2'd1;
            state_nx = (need == 2'd1) ? EVAL : STALL;
          end
        end
      end
      STALL: begin
        stall        = 1'b1;
        remaining_nx = remaining - 2'd1;
        if (remaining <= 2'd1)
          state_nx = EVAL;
      end
      EVAL: begin
        eval     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign redirect     = eval && i_taken && i_rst_n;
  assign o_stall      = stall && i_rst_n;
  assign o_cmp_branch = (eval && i_rst_n) ? eval_type : 3'b000;
  assign o_pc_sel     = redirect;
  assign o_flush_ifid = redirect;
  assign o_pc_target  = redirect ? eval_tgt : 32'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      remaining <= 2'd0;
      lat_type  <= 3'b000;
      lat_tgt   <= 32'd0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      if (latch_en) begin
        lat_type <= i_id_branch;
        lat_tgt  <= i_id_target;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_branch_cnt <= '0;
      o_taken_cnt  <= '0;
      o_stall_cnt  <= '0;
    end else begin
      if (eval && o_branch_cnt != '1)
        o_branch_cnt <= o_branch_cnt + 1'b1;
      if (redirect && o_taken_cnt != '1)
        o_taken_cnt <= o_taken_cnt + 1'b1;
      if (stall && o_stall_cnt != '1)
        o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

endmodule
